// File: rtl/rpn_pkg.sv
// rpn_pkg: shared constants and types for the RPN evaluator.
// Holds token codes, FSM state enum, ALU op enum and default sizes.
package rpn_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int W_DEF     = 32;

    // ASCII token codes, shared with the token-stack block
    localparam int unsigned TOK_ADD = 32'h0000_002B;
    localparam int unsigned TOK_SUB = 32'h0000_002D;
    localparam int unsigned TOK_MUL = 32'h0000_002A;
    localparam int unsigned TOK_EQ  = 32'h0000_003D;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        EXEC = 2'd1,
        OUT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

endpackage

// File: rtl/rpn_alu.sv
// rpn_alu: token decode and combinational a op b.
// Ports: i_tok token in; o_is_op/o_is_eq/o_op decode; i_op/i_a/i_b -> o_res.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] i_tok,
    output logic         o_is_op,
    output logic         o_is_eq,
    output op_t          o_op,
    input  op_t          i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_res
);

    // Full-width compare: 0x12B etc. are operands, not operators
    localparam logic [W-1:0] L_ADD = W'(TOK_ADD);
    localparam logic [W-1:0] L_SUB = W'(TOK_SUB);
    localparam logic [W-1:0] L_MUL = W'(TOK_MUL);
    localparam logic [W-1:0] L_EQ  = W'(TOK_EQ);

    always_comb begin
        o_is_op = 1'b0;
        o_is_eq = 1'b0;
        o_op    = OP_ADD;
        unique case (1'b1)
            (i_tok == L_ADD): begin
                o_is_op = 1'b1;
                o_op    = OP_ADD;
            end
            (i_tok == L_SUB): begin
                o_is_op = 1'b1;
                o_op    = OP_SUB;
            end
            (i_tok == L_MUL): begin
                o_is_op = 1'b1;
                o_op    = OP_MUL;
            end
            (i_tok == L_EQ): begin
                o_is_eq = 1'b1;
            end
            default: ;
        endcase
    end

    // All results wrap to W bits
    always_comb begin
        o_res = '0;
        unique case (i_op)
            OP_ADD:  o_res = i_a + i_b;
            OP_SUB:  o_res = i_a - i_b;
            OP_MUL:  o_res = i_a * i_b;
            default: o_res = '0;
        endcase
    end

endmodule

// File: rtl/rpn_eval.sv
// rpn_eval: evaluates an RPN token stream using an internal operand stack.
// Ports: CLK/RST_N; IN_STB/IN_DAT/IN_ACK token in; RES_STB/RES_DAT/RES_ERR/RES_ACK result out.
module rpn_eval
    import rpn_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = W_DEF
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         IN_STB,
    input  logic [W-1:0] IN_DAT,
    output logic         IN_ACK,
    output logic         RES_STB,
    output logic [W-1:0] RES_DAT,
    output logic         RES_ERR,
    input  logic         RES_ACK
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t         r_state;
    state_t         w_next;
    logic [DW-1:0]  r_depth;
    logic           r_err;
    op_t            r_op;
    logic [W-1:0]   r_stk [DEPTH];
    logic [W-1:0]   r_res_dat;
    logic           r_res_err;

    logic           w_acc;
    logic           w_is_op;
    logic           w_is_eq;
    op_t            w_dec_op;
    logic           w_push;
    logic           w_full;
    logic           w_two;
    logic [IW-1:0]  w_top_idx;
    logic [IW-1:0]  w_nxt_idx;
    logic [IW-1:0]  w_push_idx;
    logic [W-1:0]   w_a;
    logic [W-1:0]   w_b;
    logic [W-1:0]   w_alu_res;

    assign w_acc      = IN_STB && (r_state == RUN);
    assign w_push     = w_acc && !w_is_op && !w_is_eq;
    assign w_full     = (r_depth == DW'(DEPTH));
    assign w_two      = (r_depth >= DW'(2));
    assign w_top_idx  = IW'(r_depth - DW'(1));
    assign w_nxt_idx  = IW'(r_depth - DW'(2));
    assign w_push_idx = IW'(r_depth);
    assign w_a        = r_stk[w_nxt_idx];
    assign w_b        = r_stk[w_top_idx];

    // Gate with reset so the handshake is quiet while held in reset
    assign IN_ACK  = w_acc && RST_N;
    assign RES_STB = (r_state == OUT);
    assign RES_DAT = r_res_dat;
    assign RES_ERR = r_res_err;

    rpn_alu #(
        .W(W)
    ) u_alu (
        .i_tok   (IN_DAT),
        .o_is_op (w_is_op),
        .o_is_eq (w_is_eq),
        .o_op    (w_dec_op),
        .i_op    (r_op),
        .i_a     (w_a),
        .i_b     (w_b),
        .o_res   (w_alu_res)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            RUN: begin
                if (w_acc && w_is_op) begin
                    w_next = EXEC;
                end else if (w_acc && w_is_eq) begin
                    w_next = OUT;
                end
            end
            EXEC: w_next = RUN;
            OUT: begin
                if (RES_ACK) begin
                    w_next = RUN;
                end
            end
            default: w_next = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_depth   <= '0;
            r_err     <= 1'b0;
            r_op      <= OP_ADD;
            r_res_dat <= '0;
            r_res_err <= 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_acc) begin
                        if (w_is_op) begin
                            r_op <= w_dec_op;
                            // Underflow: flag it, EXEC then sees depth < 2 and skips
                            if (!w_two) begin
                                r_err <= 1'b1;
                            end
                        end else if (w_is_eq) begin
                            if (r_err || (r_depth != DW'(1))) begin
                                r_res_dat <= '0;
                                r_res_err <= 1'b1;
                            end else begin
                                r_res_dat <= w_b;
                                r_res_err <= 1'b0;
                            end
                        end else if (w_full) begin
                            r_err <= 1'b1;
                        end else begin
                            r_depth <= r_depth + DW'(1);
                        end
                    end
                end
                EXEC: begin
                    if (w_two) begin
                        r_depth <= r_depth - DW'(1);
                    end
                end
                OUT: begin
                    if (RES_ACK) begin
                        r_depth <= '0;
                        r_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is qualified by r_depth, so it needs no reset
    always_ff @(posedge CLK) begin
        if (w_push && !w_full) begin
            r_stk[w_push_idx] <= IN_DAT;
        end else if ((r_state == EXEC) && w_two) begin
            r_stk[w_nxt_idx] <= w_alu_res;
        end
    end

endmodule

// File: tb/tb_rpn_eval.sv
// tb_rpn_eval: directed self-checking bench for rpn_eval.
// Expected results are queued at stimulus time and popped when RES_STB rises.
module tb_rpn_eval;

    localparam logic [31:0] T_ADD = 32'h2B;
    localparam logic [31:0] T_SUB = 32'h2D;
    localparam logic [31:0] T_MUL = 32'h2A;
    localparam logic [31:0] T_EQ  = 32'h3D;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } exp_t;

    logic        CLK;
    logic        RST_N;
    logic        IN_STB;
    logic [31:0] IN_DAT;
    logic        IN_ACK;
    logic        RES_STB;
    logic [31:0] RES_DAT;
    logic        RES_ERR;
    logic        RES_ACK;

    exp_t q[$];
    int   n_vec;
    int   n_bad;
    int   last_waits;

    rpn_eval #(
        .DEPTH(8),
        .W(32)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .IN_STB  (IN_STB),
        .IN_DAT  (IN_DAT),
        .IN_ACK  (IN_ACK),
        .RES_STB (RES_STB),
        .RES_DAT (RES_DAT),
        .RES_ERR (RES_ERR),
        .RES_ACK (RES_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] tok);
        bit got;
        got = 1'b0;
        last_waits = 0;
        IN_DAT = tok;
        IN_STB = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK);
            got = IN_ACK;
            @(posedge CLK);
            #1;
            if (!got) last_waits++;
        end
        IN_STB = 1'b0;
        chk("accept", {31'b0, got}, 32'd1);
        if (tok == T_ADD || tok == T_SUB || tok == T_MUL) begin
            IN_STB = 1'b1;
            @(negedge CLK);
            chk("exec_ack_low", {31'b0, IN_ACK}, 32'd0);
            @(posedge CLK);
            #1;
            IN_STB = 1'b0;
        end else if (tok == T_EQ) begin
            @(negedge CLK);
            chk("res_stb_rise", {31'b0, RES_STB}, 32'd1);
        end
    endtask

    task automatic expect_res(input logic [31:0] dat, input logic err);
        exp_t e;
        e.dat = dat;
        e.err = err;
        q.push_back(e);
    endtask

    task automatic get_result(input string tag);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (i != 0) @(negedge CLK);
            seen = RES_STB;
        end
        chk({tag, "_stb"}, {31'b0, seen}, 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            if (seen) begin
                chk({tag, "_dat"}, RES_DAT, e.dat);
                chk({tag, "_err"}, {31'b0, RES_ERR}, {31'b0, e.err});
            end
        end
        RES_ACK = 1'b1;
        @(posedge CLK);
        #1;
        RES_ACK = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        RST_N   = 1'b0;
        IN_STB  = 1'b1;
        IN_DAT  = 32'd5;
        RES_ACK = 1'b0;

        repeat (3) @(negedge CLK);
        chk("rst_in_ack", {31'b0, IN_ACK}, 32'd0);
        chk("rst_res_stb", {31'b0, RES_STB}, 32'd0);
        chk("rst_res_dat", RES_DAT, 32'd0);
        chk("rst_res_err", {31'b0, RES_ERR}, 32'd0);
        @(posedge CLK);
        #1;
        IN_STB = 1'b0;
        RST_N  = 1'b1;

        // 3 4 + = -> 7
        send(32'd3);
        chk("first_tok_wait", last_waits, 32'd0);
        send(32'd4);
        send(T_ADD);
        send(T_EQ);
        expect_res(32'd7, 1'b0);
        get_result("add");

        // 2 3 4 * - = -> -10
        send(32'd2);
        send(32'd3);
        send(32'd4);
        send(T_MUL);
        send(T_SUB);
        send(T_EQ);
        expect_res(32'hFFFF_FFF6, 1'b0);
        get_result("mulsub");

        // operand order: 10 3 - = -> 7
        send(32'd10);
        send(32'd3);
        send(T_SUB);
        send(T_EQ);
        expect_res(32'd7, 1'b0);
        get_result("sub_order");

        // underflow then clean recovery
        send(32'd5);
        send(T_ADD);
        send(T_EQ);
        expect_res(32'd0, 1'b1);
        get_result("underflow");
        send(32'd1);
        send(T_EQ);
        expect_res(32'd1, 1'b0);
        get_result("recover1");

        // overflow: nine operands into DEPTH 8
        for (int k = 1; k <= 9; k++) send(32'(k));
        send(T_EQ);
        expect_res(32'd0, 1'b1);
        get_result("overflow");

        // signed wrap on add
        send(32'h7FFF_FFFF);
        send(32'd1);
        send(T_ADD);
        send(T_EQ);
        expect_res(32'h8000_0000, 1'b0);
        get_result("add_wrap");

        // multiply keeps low bits
        send(32'h0001_0003);
        send(32'h0001_0000);
        send(T_MUL);
        send(T_EQ);
        expect_res(32'h0003_0000, 1'b0);
        get_result("mul_low");

        // leftover depth != 1 is an error
        send(32'd4);
        send(32'd5);
        send(T_EQ);
        expect_res(32'd0, 1'b1);
        get_result("depth2");

        // 0x12B is an operand, not "+"
        send(32'h0000_012B);
        send(T_EQ);
        expect_res(32'h0000_012B, 1'b0);
        get_result("wide_tok");

        // RES_ACK ignored outside OUT
        send(32'd2);
        RES_ACK = 1'b1;
        @(posedge CLK);
        #1;
        RES_ACK = 1'b0;
        send(32'd3);
        send(T_ADD);
        send(T_EQ);
        expect_res(32'd5, 1'b0);
        get_result("ack_ignored");

        // hold result under back-pressure
        send(32'd6);
        send(T_EQ);
        expect_res(32'd6, 1'b0);
        IN_DAT = 32'd5;
        IN_STB = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("hold_stb", {31'b0, RES_STB}, 32'd1);
            chk("hold_dat", RES_DAT, 32'd6);
            chk("hold_in_ack", {31'b0, IN_ACK}, 32'd0);
        end
        get_result("hold");
        @(negedge CLK);
        chk("post_ack_stb", {31'b0, RES_STB}, 32'd0);
        chk("post_ack_in_ack", {31'b0, IN_ACK}, 32'd1);
        IN_STB = 1'b0;
        @(posedge CLK);
        #1;

        // reset mid-expression discards 9 9
        send(32'd9);
        send(32'd9);
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        send(32'd1);
        send(T_EQ);
        expect_res(32'd1, 1'b0);
        get_result("mid_reset");

        // reset while in OUT
        send(32'd4);
        send(T_EQ);
        #2;
        RST_N = 1'b0;
        #1;
        chk("out_rst_stb", {31'b0, RES_STB}, 32'd0);
        chk("out_rst_dat", RES_DAT, 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        send(32'd8);
        send(T_EQ);
        expect_res(32'd8, 1'b0);
        get_result("after_out_rst");

        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
